alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU (A, B, F[2:0] -> Q, Cout).
- Adds a valid/ready input handshake, registered results with a one-cycle out_valid strobe, a zero flag, and an iterative shift-add multiplier with a double-width result.
- Single-cycle ops sustain one result per clock.
- Sits between the operand/register-file front end and the result write-back stage.

Parameters:
- W, 8, operand and result width in bits (W >= 2).
- CW, $clog2(W)+1, multiply iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  W  operand A, sampled only on accept.
- B  input  W  operand B, sampled only on accept.
- F  input  3  opcode, sampled only on accept.
- in_valid  input  1  operands and opcode are valid this cycle.
- in_ready  output  1  block can accept this cycle.
- out_valid  output  1  one-cycle pulse; result outputs are new this cycle.
- Q  output  W  result, low half for MUL.
- Qh  output  W  high half of the MUL product; 0 for all other ops.
- Cout  output  1  carry/borrow/shift-out/overflow flag.
- Z  output  1  1 when {Qh,Q} == 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; Q=0, Qh=0, Cout=0, Z=0, out_valid=0; counter and accumulator cleared.
  - in_ready=1 after deassertion.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. A, B and F are latched; later input changes have no effect on that operation.
- in_ready = (state==IDLE). It is combinational from state only, never from in_valid.
- Opcodes (unsigned arithmetic, W-bit results):
  - 0 ADD: {Cout,Q} = A+B.
  - 1 SUB: Q = A-B mod 2^W; Cout=1 iff A<B (borrow).
  - 2 AND, 3 OR, 4 XOR: bitwise; Cout=0.
  - 5 SHL: Q = A<<1; Cout = A[W-1].
  - 6 SHR (logical): Q = A>>1; Cout = A[0].
  - 7 MUL: {Qh,Q} = A*B (2W bits); Cout = |Qh.
- Single-cycle ops (F != 7):
  - Outputs are registered on the accept edge; out_valid=1 in the following cycle.
  - State stays IDLE, so back-to-back accepts on consecutive edges each produce one out_valid pulse, in order.
- MUL FSM, states IDLE and MUL:
  - IDLE -> MUL on accept with F=7: counter=W, accumulator=0, multiplicand=A, multiplier=B.
  - Each MUL edge: if multiplier LSB=1, add multiplicand into the upper half of the 2W-bit accumulator; shift accumulator and multiplier right by 1; decrement counter.
  - MUL -> IDLE on the edge where counter goes 1 -> 0. On that edge Q, Qh, Cout and Z are loaded and out_valid is pulsed in the next cycle.
  - Latency: out_valid is high in the cycle after the W-th edge following accept (W=8: 8 edges).
  - in_ready is low for exactly W cycles.
- Output hold: Q, Qh, Cout and Z hold their last values between results. out_valid is 0 when no result is completing.
- Z is computed from the new result only, for every op.
- in_valid while in_ready=0: ignored. The operation is neither queued nor dropped-with-error, and the source must hold its request.
- Reset mid-MUL: aborts immediately. No out_valid, outputs go to their reset values, state=IDLE.
- Products at the width extreme: (2^W-1)^2 must be exact; the accumulator must not overflow.

Test Plan:
- ADD, W=8, A=250, B=12 -> next cycle out_valid=1, Q=6, Cout=1, Qh=0, Z=0; following cycle out_valid=0 and Q held at 6.
- SUB: A=3, B=4 -> Q=255, Cout=1; then A=12, B=12 -> Q=0, Cout=0, Z=1. Issue both on consecutive edges -> two consecutive out_valid pulses.
- Logic and shift, A=30, B=176:
  - AND -> Q=16.
  - OR -> Q=190.
  - XOR -> Q=174.
  - SHL -> Q=60, Cout=0.
  - SHR -> Q=15, Cout=0.
  - All with Cout=0 for the logic ops and Qh=0.
- MUL: A=250, B=12 -> in_ready low 8 cycles, then out_valid with Qh=0x0B, Q=0xB8, Cout=1. A=255, B=255 -> Qh=0xFE, Q=0x01. A=0, B=77 -> Z=1, Cout=0.
- Busy handling: assert in_valid with ADD A=1, B=1 throughout a MUL -> not accepted until in_ready returns, then produces Q=2 one cycle after that accept.
- Async reset: pulse rst_n low 3 cycles into a MUL, between clock edges -> outputs zero immediately, no out_valid, in_ready=1; a subsequent ADD 3+4 -> Q=7.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input, zero flag and an
// iterative shift-add multiplier producing a 2W-bit product.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   F,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] Q,
  output logic [W-1:0] Qh,
  output logic         Cout,
  output logic         Z
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] w_acc_nxt;
  logic [2*W-1:0] w_acc_step;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   w_mcand_nxt;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   w_mplier_nxt;

  logic [W-1:0] r_q;
  logic [W-1:0] w_q_nxt;
  logic [W-1:0] r_qh;
  logic [W-1:0] w_qh_nxt;
  logic         r_cout;
  logic         w_cout_nxt;
  logic         r_z;
  logic         w_z_nxt;
  logic         r_ovalid;
  logic         w_ovalid_nxt;

  logic         w_accept;
  logic [W:0]   w_add;
  logic [W:0]   w_sub;
  logic [W:0]   w_sum;
  logic [W-1:0] w_alu_q;
  logic         w_alu_c;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_ovalid;
  assign Q         = r_q;
  assign Qh        = r_qh;
  assign Cout      = r_cout;
  assign Z         = r_z;

  assign w_add = {1'b0, A} + {1'b0, B};
  assign w_sub = {1'b0, A} - {1'b0, B};

  always_comb begin
    w_alu_q = '0;
    w_alu_c = 1'b0;
    case (F)
      3'd0: {w_alu_c, w_alu_q} = w_add;
      3'd1: {w_alu_c, w_alu_q} = w_sub;
      3'd2: w_alu_q = A & B;
      3'd3: w_alu_q = A | B;
      3'd4: w_alu_q = A ^ B;
      3'd5: begin
        w_alu_q = {A[W-2:0], 1'b0};
        w_alu_c = A[W-1];
      end
      3'd6: begin
        w_alu_q = {1'b0, A[W-1:1]};
        w_alu_c = A[0];
      end
      default: ;
    endcase
  end

  // Extra sum bit keeps (2^W-1)^2 exact.
  assign w_sum = {1'b0, r_acc[2*W-1:W]}
               + (r_mplier[0] ? {1'b0, r_mcand}
                              : {(W+1){1'b0}});
  assign w_acc_step = {w_sum, r_acc[W-1:1]};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_q_nxt      = r_q;
    w_qh_nxt     = r_qh;
    w_cout_nxt   = r_cout;
    w_z_nxt      = r_z;
    w_ovalid_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && F == 3'd7) begin
          w_state_nxt  = S_MUL;
          w_cnt_nxt    = CW'(W);
          w_acc_nxt    = '0;
          w_mcand_nxt  = A;
          w_mplier_nxt = B;
        end else if (w_accept) begin
          w_q_nxt      = w_alu_q;
          w_qh_nxt     = '0;
          w_cout_nxt   = w_alu_c;
          w_z_nxt      = ~|w_alu_q;
          w_ovalid_nxt = 1'b1;
        end
      end
      S_MUL: begin
        w_acc_nxt    = w_acc_step;
        w_mplier_nxt = {1'b0, r_mplier[W-1:1]};
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt  = S_IDLE;
          w_q_nxt      = w_acc_step[W-1:0];
          w_qh_nxt     = w_acc_step[2*W-1:W];
          w_cout_nxt   = |w_acc_step[2*W-1:W];
          w_z_nxt      = ~|w_acc_step;
          w_ovalid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_q      <= '0;
      r_qh     <= '0;
      r_cout   <= 1'b0;
      r_z      <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_q      <= w_q_nxt;
      r_qh     <= w_qh_nxt;
      r_cout   <= w_cout_nxt;
      r_z      <= w_z_nxt;
      r_ovalid <= w_ovalid_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table through a scoreboard,
// plus busy, hold and mid-multiply reset sequences.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] qh;
    logic         c;
    logic         z;
  } vec_t;

  typedef struct {
    vec_t v;
    time  due;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   F;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] Q;
  logic [W-1:0] Qh;
  logic         Cout;
  logic         Z;

  int   checks;
  int   failures;
  sb_t  sb[$];
  sb_t  m_e;
  vec_t tbl[18];

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .F         (F),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .Q         (Q),
    .Qh        (Qh),
    .Cout      (Cout),
    .Z         (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [2:0]   f,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] q,
    input logic [W-1:0] qh,
    input logic         c,
    input logic         z
  );
    vec_t v;
    v.f = f; v.a = a; v.b = b;
    v.q = q; v.qh = qh; v.c = c; v.z = z;
    return v;
  endfunction

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_valid t=%0t Q=%0h",
                 $time, Q);
      end else begin
        m_e = sb.pop_front();
        check($sformatf("result_f%0d_%0d_%0d",
                        m_e.v.f, m_e.v.a, m_e.v.b),
              {14'd0, Qh, Q, Cout, Z},
              {14'd0, m_e.v.qh, m_e.v.q,
               m_e.v.c, m_e.v.z});
        check($sformatf("latency_f%0d_%0d_%0d",
                        m_e.v.f, m_e.v.a, m_e.v.b),
              32'($time), 32'(m_e.due));
      end
    end
  end

  task automatic issue(
    input  vec_t v,
    input  bit   push,
    output time  t_acc
  );
    int n;
    bit acc;
    n = 0;
    t_acc = 0;
    @(negedge clk);
    A = v.a;
    B = v.b;
    F = v.f;
    in_valid = 1'b1;
    forever begin
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        t_acc = $time;
        if (push) begin
          sb_t e;
          e.v = v;
          e.due = $time + 5 +
                  ((v.f == 3'd7) ? 10 * W : 0);
          sb.push_back(e);
        end
        break;
      end
      n++;
      if (n > 64) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout f=%0d", v.f);
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  initial begin
    time t0;
    time t1;
    int  lo;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    F = '0;

    tbl[0]  = mk(3'd0, 8'd250, 8'd12,  8'd6,   8'd0, 1, 0);
    tbl[1]  = mk(3'd1, 8'd3,   8'd4,   8'd255, 8'd0, 1, 0);
    tbl[2]  = mk(3'd1, 8'd12,  8'd12,  8'd0,   8'd0, 0, 1);
    tbl[3]  = mk(3'd2, 8'd30,  8'd176, 8'd16,  8'd0, 0, 0);
    tbl[4]  = mk(3'd3, 8'd30,  8'd176, 8'd190, 8'd0, 0, 0);
    tbl[5]  = mk(3'd4, 8'd30,  8'd176, 8'd174, 8'd0, 0, 0);
    tbl[6]  = mk(3'd5, 8'd30,  8'd176, 8'd60,  8'd0, 0, 0);
    tbl[7]  = mk(3'd6, 8'd30,  8'd176, 8'd15,  8'd0, 0, 0);
    tbl[8]  = mk(3'd5, 8'd200, 8'd0,   8'd144, 8'd0, 1, 0);
    tbl[9]  = mk(3'd6, 8'd3,   8'd0,   8'd1,   8'd0, 1, 0);
    tbl[10] = mk(3'd0, 8'd128, 8'd128, 8'd0,   8'd0, 1, 1);
    tbl[11] = mk(3'd1, 8'd0,   8'd1,   8'd255, 8'd0, 1, 0);
    tbl[12] = mk(3'd7, 8'd250, 8'd12,  8'hB8,  8'h0B, 1, 0);
    tbl[13] = mk(3'd7, 8'd255, 8'd255, 8'h01,  8'hFE, 1, 0);
    tbl[14] = mk(3'd7, 8'd0,   8'd77,  8'h00,  8'h00, 0, 1);
    tbl[15] = mk(3'd7, 8'd15,  8'd17,  8'hFF,  8'h00, 0, 0);
    tbl[16] = mk(3'd7, 8'd128, 8'd2,   8'h00,  8'h01, 1, 0);
    tbl[17] = mk(3'd4, 8'd85,  8'd85,  8'h00,  8'h00, 0, 1);

    repeat (2) @(negedge clk);
    check("reset_outs", {22'd0, Qh, Q, Cout, Z},
          32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    issue(tbl[0], 1'b1, t0);
    @(negedge clk);
    @(negedge clk);
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_q", {24'd0, Q}, 32'd6);

    for (int i = 0; i < 18; i++)
      issue(tbl[i], 1'b1, t0);

    issue(mk(3'd7, 8'd250, 8'd12, 8'hB8, 8'h0B, 1, 0),
          1'b1, t0);
    lo = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
      lo++;
    end
    check("mul_busy_cycles", 32'(lo), 32'(W));

    issue(mk(3'd7, 8'd7, 8'd9, 8'd63, 8'd0, 0, 0),
          1'b1, t0);
    issue(mk(3'd0, 8'd1, 8'd1, 8'd2, 8'd0, 0, 0),
          1'b1, t1);
    check("busy_accept_delay", 32'(t1 - t0),
          32'(10 * W + 10));

    repeat (3) @(negedge clk);
    issue(mk(3'd7, 8'd200, 8'd100, 8'd0, 8'd0, 0, 0),
          1'b0, t0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", {22'd0, Qh, Q, Cout, Z}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    #3 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(mk(3'd0, 8'd3, 8'd4, 8'd7, 8'd0, 0, 0),
          1'b1, t0);

    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
